// File: rtl/simd_data_mem_if.sv
// CPU data-port bundle for simd_data_mem: request, write data, lane mask and read response.
// The CPU side uses the master modport and the memory uses the slave modport.
interface simd_data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int LANE_W = 4
);
  localparam int MASK_W = DATA_W / LANE_W;

  logic              data_R;
  logic              data_W;
  logic [ADDR_W-1:0] data_address;
  logic [DATA_W-1:0] data_out;
  logic [MASK_W-1:0] wr_mask;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              busy;
  logic              err;

  modport master (
    output data_R, data_W, data_address, data_out, wr_mask,
    input  data_in, data_valid, busy, err
  );

  modport slave (
    input  data_R, data_W, data_address, data_out, wr_mask,
    output data_in, data_valid, busy, err
  );
endinterface

// File: rtl/simd_data_mem.sv
// Posedge BRAM-style SIMD data memory with a pipelined read latency, lane-masked writes,
// a busy handshake that stalls writes behind in-flight reads, and a sticky range error.
module simd_data_mem #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 10,
  parameter int    DEPTH     = 1024,
  parameter int    LANE_W    = 4,
  parameter int    RD_LAT    = 2,
  parameter string INIT_FILE = ""
) (
  input logic            clk,
  input logic            rst,
  simd_data_mem_if.slave bus
);
  localparam int MASK_W = DATA_W / LANE_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_data [RD_LAT];
  logic [DATA_W-1:0] rd_word;
  logic              rd_valid;
  logic              range_err;

  logic             rd_acc;
  logic             wr_acc;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             busy_int;

  assign busy_int = |pipe_vld;
  assign in_range = {1'b0, bus.data_address} < (ADDR_W + 1)'(DEPTH);
  assign idx      = bus.data_address[IDX_W-1:0];
  // Writes may only land while the read pipeline is empty, so a word captured at the
  // accepting edge can never go stale while it travels down the pipeline.
  assign rd_acc   = bus.data_R & ~bus.data_W & ~rst;
  assign wr_acc   = bus.data_R &  bus.data_W & ~rst & ~busy_int;

  // NOTE: the array and data pipeline carry no reset; only the valid bits and outputs do,
  // which keeps the array mappable to block RAM and preserves contents across rst.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (bus.wr_mask[i]) mem[idx][i*LANE_W +: LANE_W] <= bus.data_out[i*LANE_W +: LANE_W];
      end
    end
    pipe_data[0] <= in_range ? mem[idx] : '0;
    for (int s = 1; s < RD_LAT; s++) pipe_data[s] <= pipe_data[s-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld  <= '0;
      rd_word   <= '0;
      rd_valid  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_acc;
      for (int s = 1; s < RD_LAT; s++) pipe_vld[s] <= pipe_vld[s-1];
      rd_valid <= pipe_vld[RD_LAT-1];
      if (pipe_vld[RD_LAT-1]) rd_word <= pipe_data[RD_LAT-1];
      if ((rd_acc || wr_acc) && !in_range) range_err <= 1'b1;
    end
  end

  assign bus.data_in    = rd_word;
  assign bus.data_valid = rd_valid;
  assign bus.busy       = busy_int;
  assign bus.err        = range_err;
endmodule
